// File: rtl/koordinat_bolge_bulucu_pkg.sv
// Shared constants for the coordinate-region detector: quadrant codes, message field positions
// and the quadrant classification function.
package koordinat_pkg;

  localparam logic [1:0] BOLGE_I   = 2'b00;
  localparam logic [1:0] BOLGE_II  = 2'b01;
  localparam logic [1:0] BOLGE_III = 2'b10;
  localparam logic [1:0] BOLGE_IV  = 2'b11;

  localparam int X_MSB = 15;
  localparam int X_LSB = 8;
  localparam int Y_MSB = 7;
  localparam int Y_LSB = 0;

  // Zero counts as non-negative, so only the sign bits matter.
  function automatic logic [1:0] bolge_hesapla(input logic [7:0] x, input logic [7:0] y);
    logic [1:0] sonuc;
    unique case ({x[7], y[7]})
      2'b00:   sonuc = BOLGE_I;
      2'b10:   sonuc = BOLGE_II;
      2'b11:   sonuc = BOLGE_III;
      default: sonuc = BOLGE_IV;
    endcase
    return sonuc;
  endfunction

endpackage

// File: rtl/koordinat_bolge_bulucu_if.sv
// Message-in / region-out bundle between the receiver, the detector and the statistics logic.
interface koordinat_bolge_bulucu_if #(
  parameter int SAYAC_W = 16
) ();
  logic               mesaj_gecerli;
  logic [15:0]        mesaj;
  logic               sayac_temizle;
  logic [1:0]         bolge;
  logic               bolge_gecerli;
  logic               eksen;
  logic [SAYAC_W-1:0] sayac0;
  logic [SAYAC_W-1:0] sayac1;
  logic [SAYAC_W-1:0] sayac2;
  logic [SAYAC_W-1:0] sayac3;

  modport master (
    output mesaj_gecerli, mesaj, sayac_temizle,
    input  bolge, bolge_gecerli, eksen, sayac0, sayac1, sayac2, sayac3
  );

  modport slave (
    input  mesaj_gecerli, mesaj, sayac_temizle,
    output bolge, bolge_gecerli, eksen, sayac0, sayac1, sayac2, sayac3
  );
endinterface

// File: rtl/koordinat_bolge_bulucu_doyumlu_sayac.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module doyumlu_sayac #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         temizle,
  input  logic         artir,
  output logic [W-1:0] deger
);

  logic [W-1:0] deger_reg;
  logic [W-1:0] deger_next;

  always_comb begin
    deger_next = deger_reg;
    if (temizle) begin
      deger_next = '0;
    end else if (artir && (deger_reg != {W{1'b1}})) begin
      deger_next = deger_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deger_reg <= '0;
    end else begin
      deger_reg <= deger_next;
    end
  end

  assign deger = deger_reg;

endmodule

// File: rtl/koordinat_bolge_bulucu.sv
// Registered quadrant/axis classifier for signed 8-bit X/Y messages with one saturating
// hit counter per quadrant.
module koordinat_bolge_bulucu
  import koordinat_pkg::*;
#(
  parameter int SAYAC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  koordinat_bolge_bulucu_if.slave   bus
);

  // Reset asserts asynchronously but releases only after two clean edges.
  logic [1:0] rst_kopru_reg;
  logic       ic_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_kopru_reg <= 2'b00;
    end else begin
      rst_kopru_reg <= {rst_kopru_reg[0], 1'b1};
    end
  end

  assign ic_rst_n = rst_kopru_reg[1];

  logic [7:0] x;
  logic [7:0] y;
  logic [1:0] bolge_next;
  logic       eksen_next;

  assign x          = bus.mesaj[X_MSB:X_LSB];
  assign y          = bus.mesaj[Y_MSB:Y_LSB];
  assign bolge_next = bolge_hesapla(x, y);
  assign eksen_next = (x == 8'h00) || (y == 8'h00);

  logic [1:0] bolge_reg;
  logic       eksen_reg;
  logic       bolge_gecerli_reg;

  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      bolge_reg         <= BOLGE_I;
      eksen_reg         <= 1'b0;
      bolge_gecerli_reg <= 1'b0;
    end else begin
      bolge_gecerli_reg <= bus.mesaj_gecerli;
      if (bus.mesaj_gecerli) begin
        bolge_reg <= bolge_next;
        eksen_reg <= eksen_next;
      end
    end
  end

  logic [SAYAC_W-1:0] sayac [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sayac
      logic artir;
      assign artir = bus.mesaj_gecerli && (bolge_next == 2'(gi));

      doyumlu_sayac #(
        .W (SAYAC_W)
      ) u_sayac (
        .clk     (clk),
        .rst_n   (ic_rst_n),
        .temizle (bus.sayac_temizle),
        .artir   (artir),
        .deger   (sayac[gi])
      );
    end
  endgenerate

  assign bus.bolge         = bolge_reg;
  assign bus.eksen         = eksen_reg;
  assign bus.bolge_gecerli = bolge_gecerli_reg;
  assign bus.sayac0        = sayac[0];
  assign bus.sayac1        = sayac[1];
  assign bus.sayac2        = sayac[2];
  assign bus.sayac3        = sayac[3];

endmodule

// File: tb/tb_koordinat_bolge_bulucu.sv
// Directed bench for koordinat_bolge_bulucu: quadrant sweep, axis points, hold, reset,
// saturation with 2-bit counters, clear-vs-increment and signed extremes.
module tb_koordinat_bolge_bulucu;

  localparam int SAYAC_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_kontrol = 0;
  int   n_hata    = 0;

  always #5 clk = ~clk;

  koordinat_bolge_bulucu_if #(.SAYAC_W(SAYAC_W)) bus ();

  koordinat_bolge_bulucu #(
    .SAYAC_W (SAYAC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic kontrol_tum(input string etiket, input logic [1:0] b, input logic e, input logic g,
                             input int c0, input int c1, input int c2, input int c3);
    kontrol({etiket, ".bolge"},         32'(bus.bolge),         32'(b));
    kontrol({etiket, ".eksen"},         32'(bus.eksen),         32'(e));
    kontrol({etiket, ".bolge_gecerli"}, 32'(bus.bolge_gecerli), 32'(g));
    kontrol({etiket, ".sayac0"},        32'(bus.sayac0),        32'(c0));
    kontrol({etiket, ".sayac1"},        32'(bus.sayac1),        32'(c1));
    kontrol({etiket, ".sayac2"},        32'(bus.sayac2),        32'(c2));
    kontrol({etiket, ".sayac3"},        32'(bus.sayac3),        32'(c3));
    $display("%-12s mesaj=%04h bolge=%0d eksen=%0d gecerli=%0d sayac=%0d,%0d,%0d,%0d",
             etiket, bus.mesaj, bus.bolge, bus.eksen, bus.bolge_gecerli,
             bus.sayac0, bus.sayac1, bus.sayac2, bus.sayac3);
  endtask

  // Presents one message across one rising edge; returns at the following falling edge.
  task automatic gonder(input logic [15:0] m, input logic temizle);
    bus.mesaj_gecerli = 1'b1;
    bus.mesaj         = m;
    bus.sayac_temizle = temizle;
    @(negedge clk);
    bus.mesaj_gecerli = 1'b0;
    bus.sayac_temizle = 1'b0;
  endtask

  task automatic bosta(input int n);
    bus.mesaj_gecerli = 1'b0;
    bus.sayac_temizle = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic resetten_cik();
    @(negedge clk);
    rst_n = 1'b1;
    bosta(3);
  endtask

  initial begin
    rst_n             = 1'b1;
    bus.mesaj_gecerli = 1'b0;
    bus.mesaj         = 16'h0000;
    bus.sayac_temizle = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    kontrol_tum("reset", 2'b00, 1'b0, 1'b0, 0, 0, 0, 0);
    resetten_cik();

    // Quadrant sweep, back to back
    gonder(16'hF00F, 1'b0); kontrol_tum("F00F", 2'b01, 1'b0, 1'b1, 0, 1, 0, 0);
    gonder(16'h0FF0, 1'b0); kontrol_tum("0FF0", 2'b11, 1'b0, 1'b1, 0, 1, 0, 1);
    gonder(16'hA69E, 1'b0); kontrol_tum("A69E", 2'b10, 1'b0, 1'b1, 0, 1, 1, 1);
    gonder(16'h0220, 1'b0); kontrol_tum("0220", 2'b00, 1'b0, 1'b1, 1, 1, 1, 1);

    // Axis points keep their quadrant and still count
    gonder(16'hF000, 1'b0); kontrol_tum("F000", 2'b01, 1'b1, 1'b1, 1, 2, 1, 1);
    gonder(16'h0000, 1'b0); kontrol_tum("0000", 2'b00, 1'b1, 1'b1, 2, 2, 1, 1);
    gonder(16'h7F00, 1'b0); kontrol_tum("7F00", 2'b00, 1'b1, 1'b1, 3, 2, 1, 1);

    // Hold: mesaj changes without valid
    bus.mesaj = 16'h8080;
    bosta(1); kontrol_tum("tut1", 2'b00, 1'b1, 1'b0, 3, 2, 1, 1);
    bosta(1); kontrol_tum("tut2", 2'b00, 1'b1, 1'b0, 3, 2, 1, 1);

    // Asynchronous reset mid-stream, with a message in flight
    bus.mesaj_gecerli = 1'b1;
    bus.mesaj         = 16'hA69E;
    #2 rst_n = 1'b0;
    #1 kontrol_tum("ara_reset", 2'b00, 1'b0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    kontrol_tum("reset_tut", 2'b00, 1'b0, 1'b0, 0, 0, 0, 0);
    bus.mesaj_gecerli = 1'b0;
    resetten_cik();
    kontrol_tum("reset_sonra", 2'b00, 1'b0, 1'b0, 0, 0, 0, 0);

    // Saturation of a 2-bit counter
    gonder(16'h0101, 1'b0); kontrol_tum("doy1", 2'b00, 1'b0, 1'b1, 1, 0, 0, 0);
    gonder(16'h0101, 1'b0); kontrol_tum("doy2", 2'b00, 1'b0, 1'b1, 2, 0, 0, 0);
    gonder(16'h0101, 1'b0); kontrol_tum("doy3", 2'b00, 1'b0, 1'b1, 3, 0, 0, 0);
    gonder(16'h0101, 1'b0); kontrol_tum("doy4", 2'b00, 1'b0, 1'b1, 3, 0, 0, 0);
    gonder(16'h0101, 1'b0); kontrol_tum("doy5", 2'b00, 1'b0, 1'b1, 3, 0, 0, 0);

    // Clear wins over a simultaneous increment
    gonder(16'h0101, 1'b1); kontrol_tum("temizle", 2'b00, 1'b0, 1'b1, 0, 0, 0, 0);
    bosta(1);               kontrol_tum("temiz_bos", 2'b00, 1'b0, 1'b0, 0, 0, 0, 0);

    // Signed extremes
    gonder(16'h8080, 1'b0); kontrol_tum("8080", 2'b10, 1'b0, 1'b1, 0, 0, 1, 0);
    gonder(16'h7F7F, 1'b0); kontrol_tum("7F7F", 2'b00, 1'b0, 1'b1, 1, 0, 1, 0);
    gonder(16'h807F, 1'b0); kontrol_tum("807F", 2'b01, 1'b0, 1'b1, 1, 1, 1, 0);
    gonder(16'h7F80, 1'b0); kontrol_tum("7F80", 2'b11, 1'b0, 1'b1, 1, 1, 1, 1);
    bosta(1);               kontrol_tum("uc_bos", 2'b11, 1'b0, 1'b0, 1, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule

// File: doc/koordinat_bolge_bulucu.md
Name: koordinat_bolge_bulucu

Overview:
- Registered coordinate-region detector. Each 16-bit message carries a signed 8-bit X and a signed 8-bit Y coordinate.
- The block classifies the point into one of four quadrants, and separately flags points that lie on an axis.
- It keeps saturating per-quadrant hit counters.
- Sits between the message receiver and the downstream region-based control/statistics logic.

Parameters:
- SAYAC_W, 16, width of each per-quadrant hit counter (allowed range 1..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock domain only.
- mesaj_gecerli  input  1  message valid strobe, one accepted message per cycle while high.
- mesaj  input  16  message; [15:8] = X, [7:0] = Y, both two's complement.
- sayac_temizle  input  1  synchronous clear of all hit counters.
- bolge  output  2  quadrant code of last accepted message.
- bolge_gecerli  output  1  one-cycle pulse: bolge/eksen updated this cycle.
- eksen  output  1  last accepted point has X==0 or Y==0.
- sayac0..sayac3  output  SAYAC_W each  hit count for quadrant codes 00..11.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - bolge=2'b00, eksen=0, bolge_gecerli=0, all counters=0.
  - A message in flight is discarded.
  - Release of reset is synchronized by the usual codebase reset bridge.
- Quadrant rule, with zero treated as non-negative:
  - X>=0, Y>=0 -> 00.
  - X<0, Y>=0 -> 01.
  - X<0, Y<0 -> 10.
  - X>=0, Y<0 -> 11.
  - Equivalently: bolge = {mesaj[7], mesaj[15]^mesaj[7]}.
- eksen = (X==8'h00) || (Y==8'h00). It does not change the quadrant code.
- Latency: mesaj sampled on the edge where mesaj_gecerli=1. At that same edge:
  - bolge, eksen are registered.
  - bolge_gecerli is set high for exactly one cycle.
  - The matching counter is incremented.
- Outputs are visible in the following cycle.
- While mesaj_gecerli=0: bolge/eksen hold their value, bolge_gecerli=0, counters hold.
- Back-to-back messages are accepted every cycle, with no stall or backpressure.
- Counters:
  - Saturate at all-ones; no wrap.
  - Points on an axis still count in their quadrant.
- sayac_temizle=1 clears all counters at the edge. If a valid message arrives in the same cycle:
  - The clear wins; the message's increment is dropped.
  - bolge/eksen/bolge_gecerli still update normally.
- No X/Z propagation: mesaj is only sampled when mesaj_gecerli=1.

Decomposition:
- Shared package koordinat_pkg:
  - Quadrant code constants BOLGE_I=2'b00, BOLGE_II=2'b01, BOLGE_III=2'b10, BOLGE_IV=2'b11.
  - Field positions X_MSB=15, X_LSB=8, Y_MSB=7, Y_LSB=0.
- One sub-module doyumlu_sayac (saturating counter with increment and sync clear), instantiated four times.
- Classification is combinational inside the top block.

Test Plan:
- Reset: assert rst_n=0 mid-stream after several messages -> immediately bolge=00, eksen=0, bolge_gecerli=0, all counters 0.
- Quadrant sweep, one message per cycle, all expecting eksen=0 and bolge_gecerli pulsing each cycle:
  - 16'hF00F -> 01.
  - 16'h0FF0 -> 11.
  - 16'hA69E -> 10.
  - 16'h0220 -> 00.
- Axis cases:
  - 16'hF000 -> bolge 01, eksen 1.
  - 16'h0000 -> bolge 00, eksen 1.
  - 16'h7F00 -> bolge 00, eksen 1.
- Hold: mesaj changes to 16'h8080 with mesaj_gecerli=0 -> bolge/eksen/counters unchanged, bolge_gecerli=0.
- Counter saturation (SAYAC_W=2): five 16'h0101 messages -> sayac0=3, others 0. Then sayac_temizle together with valid 16'h0101 -> all counters 0, bolge=00, bolge_gecerli=1.
- Boundary extremes:
  - 16'h8080 -> 10.
  - 16'h7F7F -> 00.
  - 16'h807F -> 01.
  - 16'h7F80 -> 11.
  - Afterwards counters are 1,1,1,1.
